// File: rtl/bullet_launcher.sv
// Fire controller: turns the fire button into rate-limited launches into the lowest free bullet slot.
// Holds start/direction until the chosen slot acknowledges via in_use, then cools down.
module bullet_launcher #(
  parameter int NUM_BULLETS = 4,
  parameter int COOLDOWN    = 15,
  parameter int ARM_TIMEOUT = 3,
  parameter int REPEAT      = 30
) (
  input  logic                   clk_60hz,
  input  logic                   reset,
  input  logic                   fire_btn,
  input  logic                   fire_dir,
  input  logic [NUM_BULLETS-1:0] in_use,
  output logic [NUM_BULLETS-1:0] start_bullet,
  output logic                   direction,
  output logic                   busy,
  output logic                   no_slot,
  output logic [7:0]             shots_fired
);

  // state    | meaning
  // IDLE     | waiting for a request or a buffered (pending) request
  // ARM      | start held to the selected slot until it reports in_use
  // COOLDOWN | rate limit after an acknowledged launch
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COOLDOWN} state_t;

  localparam int SEL_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CD_W  = (COOLDOWN > 1)    ? $clog2(COOLDOWN)    : 1;
  localparam int AT_W  = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int RP_W  = (REPEAT > 1)      ? $clog2(REPEAT)      : 1;

  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(ARM_TIMEOUT - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT - 1);

  state_t                 state_q;
  logic                   sync1_q, fire_s_q, fire_q;
  logic [RP_W-1:0]        rpt_q, rpt_d;
  logic                   pending_q;
  logic [NUM_BULLETS-1:0] start_q;
  logic                   dir_q, busy_q, no_slot_q;
  logic [7:0]             shots_q;
  logic [SEL_W-1:0]       sel_q;
  logic [AT_W-1:0]        armtmr_q;
  logic [CD_W-1:0]        cd_q;

  logic             press, repeat_hit, request;
  logic             free_found;
  logic [SEL_W-1:0] free_idx;

  always_comb begin
    press      = fire_s_q & ~fire_q;
    repeat_hit = (REPEAT != 0) && fire_s_q && !press && (rpt_q == RP_LAST);
    request    = press | repeat_hit;
    if (!fire_s_q || press || repeat_hit) rpt_d = '0;
    else                                  rpt_d = rpt_q + RP_W'(1);
  end

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b0;
      fire_s_q  <= 1'b0;
      fire_q    <= 1'b0;
      rpt_q     <= '0;
      pending_q <= 1'b0;
      start_q   <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      no_slot_q <= 1'b0;
      shots_q   <= '0;
      sel_q     <= '0;
      armtmr_q  <= '0;
      cd_q      <= '0;
    end else begin
      sync1_q   <= fire_btn;
      fire_s_q  <= sync1_q;
      fire_q    <= fire_s_q;
      rpt_q     <= rpt_d;
      no_slot_q <= 1'b0;
      if (request && state_q != S_IDLE) pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (request || pending_q) begin
            pending_q <= 1'b0;
            if (free_found) begin
              start_q  <= NUM_BULLETS'(1) << free_idx;
              dir_q    <= fire_dir;
              sel_q    <= free_idx;
              armtmr_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_ARM;
            end else begin
              no_slot_q <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (in_use[sel_q]) begin
            start_q <= '0;
            shots_q <= shots_q + 8'd1;
            cd_q    <= '0;
            if (COOLDOWN == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_COOLDOWN;
            end
          end else if (armtmr_q == AT_LAST) begin
            start_q   <= '0;
            no_slot_q <= 1'b1;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            armtmr_q <= armtmr_q + AT_W'(1);
          end
        end
        S_COOLDOWN: begin
          if (cd_q == CD_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cd_q <= cd_q + CD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_bullet = start_q;
  assign direction    = dir_q;
  assign busy         = busy_q;
  assign no_slot      = no_slot_q;
  assign shots_fired  = shots_q;

endmodule

// File: doc/bullet_launcher.md
Name: bullet_launcher

Overview:
- Fire controller that sits directly upstream of the bank of bullet slot instances.
- Converts the raw fire button into rate-limited launch requests and allocates the lowest free bullet slot.
- Drives that slot's start_bullet and direction and holds them until the slot reports in-use (request/acknowledge handshake).
- Provides cooldown, one-deep request buffering, optional auto-repeat and a shot counter for the score/HUD logic.

Parameters:
NUM_BULLETS, 4, number of bullet slots; width of in_use/start_bullet
COOLDOWN, 15, clk_60hz ticks spent in COOLDOWN after a successful launch (0 = none)
ARM_TIMEOUT, 3, max ticks start is held without acknowledge before abort (>=2)
REPEAT, 30, auto-repeat period in ticks while fire held (0 = disabled)

Ports:
clk_60hz  in  1  game tick clock; all state on rising edge
reset  in  1  asynchronous, active-high
fire_btn  in  1  raw, unsynchronised fire button
fire_dir  in  1  requested direction: 1 = up, 0 = down
in_use  in  NUM_BULLETS  per-slot in-use flags from the bullet slots
start_bullet  out  NUM_BULLETS  one-hot launch request to the selected slot
direction  out  1  direction presented to the slots; stable while start_bullet != 0
busy  out  1  high whenever state != IDLE
no_slot  out  1  one-tick pulse when a request is dropped or aborted
shots_fired  out  8  count of acknowledged launches; wraps 255 -> 0

Behaviour:
- Reset (async): state IDLE; start_bullet = 0; direction = 0; busy = 0; no_slot = 0; shots_fired = 0; sync FFs, pending, all counters = 0. Assertion in ARM drops start_bullet immediately, without waiting for a clock edge.
- Input sync: fire_btn -> 2-FF synchroniser -> fire_s; fire_q = fire_s delayed one tick.
  - press = fire_s & ~fire_q.
  - Raw rise before edge N gives press high during tick after N+1; it is acted on at edge N+2.
- Auto-repeat (REPEAT != 0):
  - rpt counter clears when fire_s = 0 or press = 1; otherwise it increments.
  - When rpt == REPEAT-1 it produces a request and clears.
- request = press | repeat_hit.
- pending: set by a request while state != IDLE; cleared when IDLE consumes it. One deep, so further requests while pending are dropped silently.
- IDLE:
  - Acts on request | pending, using in_use as registered this edge.
  - k = lowest index with in_use[k] = 0.
  - If a slot is found: start_bullet <= onehot(k); direction <= fire_dir; sel <= k; armtmr <= 0; go to ARM.
  - If no slot: no_slot pulse for 1 tick; pending cleared; stay IDLE.
- ARM:
  - start_bullet and direction are held constant.
  - If in_use[sel] = 1: start_bullet <= 0; shots_fired++; cd <= 0; go to COOLDOWN, or to IDLE when COOLDOWN = 0.
  - Else if armtmr == ARM_TIMEOUT-1: start_bullet <= 0; no_slot pulse; go to IDLE; shots_fired unchanged.
  - Else armtmr++.
  - Requests arriving in ARM only set pending.
- Expected handshake with a slot:
  - Edge E0: start rises.
  - Edge E1: slot captures it and sets inUse.
  - Edge E2: launcher sees in_use[sel] and drops start, so start is high for exactly 2 ticks.
- COOLDOWN: cd increments each tick; on cd == COOLDOWN-1 go to IDLE.
- Minimum start-to-start spacing is 2 + COOLDOWN + 1 ticks, i.e. 18 with defaults.
- Slot change during ARM: in_use of slots other than sel is ignored. A slot freeing in the same tick a request is evaluated is seen only from the next edge.
- Width rules:
  - Counters are sized with $clog2 of their parameter (minimum 1 bit).
  - shots_fired is modulo 256.
  - start_bullet is never multi-hot.

Test Plan:
- Single press: reset, in_use = 0000, fire_dir = 1, pulse fire_btn 5 ticks; bench models slots (inUse set on start) -> start_bullet = 0001 for exactly 2 ticks, direction = 1, shots_fired = 1, busy high 2+15 ticks.
- Allocation: in_use = 0111, press -> start_bullet = 1000; in_use = 1010, press -> 0001.
- Full: in_use = 1111, press -> single-tick no_slot, start_bullet stays 0000, shots_fired unchanged.
- Buffering: press, then two more presses during COOLDOWN -> exactly 2 launches total. Second start rises 18 ticks after the first; third press is dropped.
- Timeout: bench never raises in_use -> start_bullet = 0001 for exactly ARM_TIMEOUT = 3 ticks, then no_slot pulse, shots_fired = 0. Assert reset mid-ARM in a second run -> start_bullet = 0 before the next edge.
- Auto-repeat: hold fire_btn 100 ticks, slots modelled, REPEAT = 30 -> 4 launches at press+0/30/60/90, shots_fired = 4; REPEAT = 0 -> 1 launch.
